// File: rtl/exp_align_shifter.sv
// Half-precision adder alignment stage: picks the larger-exponent operand and
// right-shifts the other significand one bit per cycle with guard/round/sticky.
module exp_align_shifter #(
  parameter int MAN_W     = 11,
  parameter int EXP_W     = 5,
  parameter int MAX_SHIFT = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] exp_a,
  input  logic [EXP_W-1:0] exp_b,
  input  logic [MAN_W-1:0] man_a,
  input  logic [MAN_W-1:0] man_b,
  input  logic [EXP_W-1:0] exp_diff,
  input  logic             diff_neg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] exp_max,
  output logic [MAN_W-1:0] man_big,
  output logic [MAN_W+2:0] man_small,
  output logic             swapped
);

  localparam int CNT_W = $clog2(MAX_SHIFT + 1);
  localparam logic [EXP_W-1:0] MAX_E = EXP_W'(MAX_SHIFT);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic [EXP_W-1:0]   diff_clamp;

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign accept     = in_valid && in_ready;
  assign diff_clamp = (exp_diff > MAX_E) ? MAX_E : exp_diff;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = SHIFT;
      SHIFT:   if (cnt == '0) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Sticky keeps the OR of every bit that has fallen off the bottom.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      exp_max   <= '0;
      man_big   <= '0;
      man_small <= '0;
      swapped   <= 1'b0;
    end else if (accept) begin
      swapped   <= diff_neg;
      man_big   <= diff_neg ? man_b : man_a;
      exp_max   <= diff_neg ? exp_b : exp_a;
      man_small <= {(diff_neg ? man_a : man_b), 3'b000};
      cnt       <= CNT_W'(diff_clamp);
    end else if (state == SHIFT && cnt != '0) begin
      man_small <= {1'b0, man_small[MAN_W+2:2],
                    man_small[1] | man_small[0]};
      cnt       <= cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_exp_align_shifter.sv
// Randomized self-checking bench for exp_align_shifter against an
// arithmetic alignment model.
module tb_exp_align_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  exp_a, exp_b, exp_diff;
  logic [10:0] man_a, man_b;
  logic        diff_neg;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  exp_max;
  logic [10:0] man_big;
  logic [13:0] man_small;
  logic        swapped;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  exp_align_shifter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .exp_a     (exp_a),
    .exp_b     (exp_b),
    .man_a     (man_a),
    .man_b     (man_b),
    .exp_diff  (exp_diff),
    .diff_neg  (diff_neg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .exp_max   (exp_max),
    .man_big   (man_big),
    .man_small (man_small),
    .swapped   (swapped)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] align_ref(input logic [10:0] m,
                                             input int d);
    int unsigned x, k, mask;
    k    = (d > 13) ? 13 : d;
    x    = {18'd0, m, 3'b000};
    mask = (32'd1 << (k + 1)) - 1;
    return ((x >> k) & ~32'd1) | ((x & mask) != 0 ? 32'd1 : 32'd0);
  endfunction

  task automatic scramble();
    exp_a    = 5'($urandom);
    exp_b    = 5'($urandom);
    man_a    = 11'($urandom);
    man_b    = 11'($urandom);
    exp_diff = 5'($urandom);
    diff_neg = 1'($urandom);
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic drive(input logic [4:0] ea, input logic [4:0] eb,
                       input logic [10:0] ma, input logic [10:0] mb,
                       input logic [4:0] d, input logic neg);
    wait_ready();
    exp_a = ea; exp_b = eb; man_a = ma; man_b = mb;
    exp_diff = d; diff_neg = neg; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    scramble();
  endtask

  task automatic run_op(input logic [4:0] ea, input logic [4:0] eb,
                        input logic [10:0] ma, input logic [10:0] mb,
                        input logic [4:0] d, input logic neg,
                        input int hold);
    int lat = 0;
    int k;
    logic [31:0] snap;
    k = (d > 13) ? 13 : int'(d);
    drive(ea, eb, ma, mb, d, neg);
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    check("latency", lat, 2 + k);
    check("exp_max", exp_max, neg ? eb : ea);
    check("man_big", man_big, neg ? mb : ma);
    check("man_small", man_small, align_ref(neg ? ma : mb, int'(d)));
    check("swapped", swapped, neg);
    snap = {man_small, man_big, exp_max, swapped, out_valid};
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_stable",
            {man_small, man_big, exp_max, swapped, out_valid}, snap);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_valid", out_valid, 0);
    check("post_hs_ready", in_ready, 1);
  endtask

  task automatic check_zeroed(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_data"}, {exp_max, man_big, man_small, swapped}, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    scramble();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zeroed("reset");
    rst = 1'b0;

    run_op(5'd15, 5'd15, 11'h400, 11'h600, 5'd0, 1'b0, 0);
    run_op(5'd13, 5'd15, 11'h600, 11'h500, 5'd2, 1'b1, 0);
    run_op(5'd20, 5'd7, 11'h7ff, 11'h401, 5'd13, 1'b0, 0);
    run_op(5'd31, 5'd1, 11'h7ff, 11'h401, 5'd30, 1'b0, 0);
    run_op(5'd25, 5'd5, 11'h555, 11'h000, 5'd20, 1'b0, 0);
    run_op(5'd9, 5'd3, 11'h4a1, 11'h7c3, 5'd6, 1'b0, 5);

    drive(5'd20, 5'd10, 11'h432, 11'h5a5, 5'd10, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zeroed("mid_reset");
    run_op(5'd12, 5'd8, 11'h6b1, 11'h4f7, 5'd4, 1'b0, 0);

    for (int i = 0; i < 30; i++) begin
      run_op(5'($urandom), 5'($urandom), 11'($urandom), 11'($urandom),
             5'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
